// File: rtl/irq_pending_arb_if.sv
// Offer channel from the pending arbiter to the priority encoder stage.
// Producer drives code/valid; consumer drives ready.
interface irq_pending_arb_if;
  logic [1:0] code;
  logic       valid;
  logic       ready;

  modport master (output code, output valid, input ready);
  modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/irq_pending_arb.sv
// Edge-capturing pending latch for 4 request lines, offering the highest pending index;
// offer is valid SYNC_STAGES+1 edges after a request edge and is held frozen until ready.
module irq_pending_arb #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [3:0]       req,
  input  logic             ovf_clr,
  irq_pending_arb_if.master irq,
  output logic [3:0]       pending,
  output logic             overflow
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [3:0] s;
  logic [3:0] s_q;
  logic [3:0] edges;
  logic [3:0] set_v;
  logic [3:0] clr_v;
  logic [3:0] ovf_hit;
  logic [1:0] sel;
  logic       accept;
  logic [0:0] state;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = req;
    end else begin : g_sync
      logic [3:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= req;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign accept    = irq.valid & irq.ready;
  assign irq.valid = (state == OFFER);
  assign edges     = s & ~s_q;
  assign set_v     = edges & {4{enable}};
  assign ovf_hit   = set_v & pending & ~clr_v;

  always_comb begin
    clr_v = '0;
    if (accept) clr_v[irq.code] = 1'b1;
  end

  // Highest set bit wins; only registered pending takes part in selection.
  always_comb begin
    sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (pending[i]) sel = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      irq.code <= '0;
    end else begin
      s_q     <= s;
      // A set landing on the bit being served keeps it pending.
      pending <= set_v | (pending & ~clr_v);
      if (|ovf_hit)     overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      case (state)
        IDLE: begin
          if (|pending) begin
            irq.code <= sel;
            state    <= OFFER;
          end
        end
        OFFER: begin
          if (accept) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_arb.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_irq_pending_arb;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] req;
  logic       ovf_clr;
  logic [3:0] pending;
  logic       overflow;
  int         checks = 0;
  int         failures = 0;

  irq_pending_arb_if irq();

  irq_pending_arb #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req      (req),
    .ovf_clr  (ovf_clr),
    .irq      (irq),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: req delay line as a queue, pending as a set of bits,
  // offer as a (busy, code) pair chosen by magnitude of the pending word.
  logic [3:0] line_q [$];
  logic [3:0] m_prev_s = 4'h0;
  logic [3:0] m_pend = 4'h0;
  logic       m_ovf = 1'b0;
  logic       m_valid = 1'b0;
  logic [1:0] m_code = 2'd0;

  always @(posedge clk) begin
    logic [3:0] s_now;
    logic [3:0] npend;
    bit         acc;
    bit         hit;
    if (!rst_n) begin
      line_q.delete();
      for (int i = 0; i < S; i++) line_q.push_back(4'h0);
      m_prev_s = 4'h0;
      m_pend   = 4'h0;
      m_ovf    = 1'b0;
      m_valid  = 1'b0;
      m_code   = 2'd0;
    end else begin
      if (S == 0) s_now = req;
      else        s_now = line_q[0];
      acc   = m_valid && irq.ready;
      npend = m_pend;
      hit   = 0;
      for (int i = 0; i < 4; i++) begin
        bit rise;
        bit served;
        rise   = s_now[i] && !m_prev_s[i] && enable;
        served = acc && (int'(m_code) == i);
        if (rise && m_pend[i] && !served) hit = 1;
        if (rise)        npend[i] = 1'b1;
        else if (served) npend[i] = 1'b0;
      end
      if (hit)          m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (m_valid) begin
        if (acc) m_valid = 1'b0;
      end else if (m_pend != 4'h0) begin
        m_valid = 1'b1;
        if (m_pend >= 4'd8)      m_code = 2'd3;
        else if (m_pend >= 4'd4) m_code = 2'd2;
        else if (m_pend >= 4'd2) m_code = 2'd1;
        else                     m_code = 2'd0;
      end
      m_pend   = npend;
      m_prev_s = s_now;
      if (S > 0) begin
        void'(line_q.pop_front());
        line_q.push_back(req);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; req = 4'h0; ovf_clr = 1'b0; irq.ready = 1'b0;
    step(2);
    checks++;
    if ({pending, overflow, irq.valid, irq.code} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {pending, overflow, irq.valid, irq.code}, 8'h00);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if ({pending, overflow, irq.valid, irq.code} !== 8'h00) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", {pending, overflow, irq.valid, irq.code}, 8'h00);
    end
  endtask

  task automatic test_single();
    req = 4'b0001;
    step(2);
    checks++;
    if (pending !== 4'b0000) begin
      failures++; $display("FAIL single_pend_early got=%b exp=0000", pending);
    end
    step(1);
    checks++;
    if ({pending, irq.valid} !== 5'b0001_0) begin
      failures++; $display("FAIL single_pend got=%b exp=%b", {pending, irq.valid}, 5'b0001_0);
    end
    step(1);
    checks++;
    if ({irq.valid, irq.code, pending} !== 7'b1_00_0001) begin
      failures++; $display("FAIL single_offer got=%b exp=%b", {irq.valid, irq.code, pending}, 7'b1_00_0001);
    end
    for (int k = 0; k < 5; k++) begin
      step(1);
      checks++;
      if ({irq.valid, irq.code} !== 3'b1_00) begin
        failures++; $display("FAIL single_hold cyc=%0d got=%b exp=100", k, {irq.valid, irq.code});
      end
    end
    irq.ready = 1'b1;
    step(1);
    checks++;
    if ({irq.valid, pending} !== 5'b0_0000) begin
      failures++; $display("FAIL single_accept got=%b exp=00000", {irq.valid, pending});
    end
    irq.ready = 1'b0; req = 4'h0;
    step(4);
  endtask

  task automatic test_priority();
    req = 4'b0101; irq.ready = 1'b1;
    step(3);
    checks++;
    if ({pending, irq.valid} !== 5'b0101_0) begin
      failures++; $display("FAIL prio_pend got=%b exp=%b", {pending, irq.valid}, 5'b0101_0);
    end
    step(1);
    checks++;
    if ({irq.valid, irq.code} !== 3'b1_10) begin
      failures++; $display("FAIL prio_first got=%b exp=110", {irq.valid, irq.code});
    end
    step(1);
    checks++;
    if ({irq.valid, pending} !== 5'b0_0001) begin
      failures++; $display("FAIL prio_gap got=%b exp=00001", {irq.valid, pending});
    end
    step(1);
    checks++;
    if ({irq.valid, irq.code} !== 3'b1_00) begin
      failures++; $display("FAIL prio_second got=%b exp=100", {irq.valid, irq.code});
    end
    step(1);
    checks++;
    if ({irq.valid, pending} !== 5'b0_0000) begin
      failures++; $display("FAIL prio_done got=%b exp=00000", {irq.valid, pending});
    end
    irq.ready = 1'b0; req = 4'h0;
    step(4);
  endtask

  task automatic test_no_preempt();
    req = 4'b0010; irq.ready = 1'b0;
    step(4);
    checks++;
    if ({irq.valid, irq.code} !== 3'b1_01) begin
      failures++; $display("FAIL nopre_offer got=%b exp=101", {irq.valid, irq.code});
    end
    req = 4'b1010;
    step(3);
    checks++;
    if ({pending, irq.valid, irq.code} !== 7'b1010_1_01) begin
      failures++; $display("FAIL nopre_frozen got=%b exp=%b", {pending, irq.valid, irq.code}, 7'b1010_1_01);
    end
    irq.ready = 1'b1;
    step(1);
    irq.ready = 1'b0;
    checks++;
    if ({irq.valid, pending} !== 5'b0_1000) begin
      failures++; $display("FAIL nopre_accept got=%b exp=01000", {irq.valid, pending});
    end
    step(1);
    checks++;
    if ({irq.valid, irq.code} !== 3'b1_11) begin
      failures++; $display("FAIL nopre_next got=%b exp=111", {irq.valid, irq.code});
    end
    irq.ready = 1'b1;
    step(1);
    irq.ready = 1'b0;
    step(1);
    checks++;
    if ({irq.valid, pending} !== 5'b0_0000) begin
      failures++; $display("FAIL nopre_empty got=%b exp=00000", {irq.valid, pending});
    end
    req = 4'h0;
    step(4);
  endtask

  task automatic test_collision_overflow();
    req = 4'b0100; irq.ready = 1'b0;
    step(4);
    checks++;
    if ({irq.valid, irq.code} !== 3'b1_10) begin
      failures++; $display("FAIL coll_offer got=%b exp=110", {irq.valid, irq.code});
    end
    req = 4'b0000;
    step(1);
    req = 4'b0100;
    step(2);
    irq.ready = 1'b1;
    step(1);
    irq.ready = 1'b0;
    checks++;
    if ({pending, overflow, irq.valid} !== 6'b0100_0_0) begin
      failures++; $display("FAIL coll_setwins got=%b exp=%b", {pending, overflow, irq.valid}, 6'b0100_0_0);
    end
    step(1);
    checks++;
    if ({irq.valid, irq.code} !== 3'b1_10) begin
      failures++; $display("FAIL coll_reoffer got=%b exp=110", {irq.valid, irq.code});
    end
    irq.ready = 1'b1;
    step(1);
    irq.ready = 1'b0;
    req = 4'b0101;
    step(4);
    checks++;
    if ({pending, irq.valid, irq.code} !== 7'b0001_1_00) begin
      failures++; $display("FAIL ovf_setup got=%b exp=%b", {pending, irq.valid, irq.code}, 7'b0001_1_00);
    end
    req = 4'b0100;
    step(1);
    req = 4'b0101;
    step(3);
    checks++;
    if ({overflow, pending} !== 5'b1_0001) begin
      failures++; $display("FAIL ovf_set got=%b exp=10001", {overflow, pending});
    end
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clr got=%b exp=0", overflow);
    end
    irq.ready = 1'b1;
    step(1);
    irq.ready = 1'b0;
    req = 4'h0;
    step(4);
  endtask

  task automatic test_enable_gating();
    enable = 1'b0; req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++;
      if ({pending, irq.valid} !== 5'b0000_0) begin
        failures++; $display("FAIL en_gated cyc=%0d got=%b exp=00000", k, {pending, irq.valid});
      end
    end
    enable = 1'b1;
    step(3);
    checks++;
    if ({pending, irq.valid} !== 5'b0000_0) begin
      failures++; $display("FAIL en_level got=%b exp=00000", {pending, irq.valid});
    end
    req = 4'b0000;
    step(1);
    req = 4'b1111;
    step(3);
    checks++;
    if (pending !== 4'b1111) begin
      failures++; $display("FAIL en_recapture got=%b exp=1111", pending);
    end
    irq.ready = 1'b1;
    step(8);
    irq.ready = 1'b0;
    checks++;
    if ({pending, irq.valid} !== 5'b0000_0) begin
      failures++; $display("FAIL en_drain got=%b exp=00000", {pending, irq.valid});
    end
    req = 4'h0;
    step(4);
  endtask

  task automatic test_reset_mid_offer();
    req = 4'b1001; irq.ready = 1'b0;
    step(4);
    checks++;
    if ({pending, irq.valid, irq.code} !== 7'b1001_1_11) begin
      failures++; $display("FAIL rmo_offer got=%b exp=%b", {pending, irq.valid, irq.code}, 7'b1001_1_11);
    end
    rst_n = 1'b0;
    step(1);
    checks++;
    if ({pending, overflow, irq.valid, irq.code} !== 8'h00) begin
      failures++; $display("FAIL rmo_reset got=%b exp=00000000", {pending, overflow, irq.valid, irq.code});
    end
    rst_n = 1'b1;
    step(2);
    checks++;
    if (pending !== 4'b0000) begin
      failures++; $display("FAIL rmo_early got=%b exp=0000", pending);
    end
    step(1);
    checks++;
    if ({pending, irq.valid} !== 5'b1001_0) begin
      failures++; $display("FAIL rmo_recapture got=%b exp=10010", {pending, irq.valid});
    end
    step(1);
    checks++;
    if ({irq.valid, irq.code} !== 3'b1_11) begin
      failures++; $display("FAIL rmo_reoffer got=%b exp=111", {irq.valid, irq.code});
    end
    irq.ready = 1'b1;
    step(3);
    irq.ready = 1'b0;
    req = 4'h0;
    step(4);
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int k = 0; k < 600; k++) begin
      checks++;
      if ({pending, overflow, irq.valid, irq.code} !== {m_pend, m_ovf, m_valid, m_code}) begin
        failures++;
        $display("FAIL rand_vs_model cyc=%0d got=%b exp=%b", k,
                 {pending, overflow, irq.valid, irq.code}, {m_pend, m_ovf, m_valid, m_code});
      end
      r         = $urandom;
      req       = req ^ (r[3:0] & r[7:4]);
      enable    = (r[11:8] != 4'h0);
      irq.ready = r[12] | r[13];
      ovf_clr   = (r[19:16] == 4'h0);
      rst_n     = (r[27:20] != 8'h00);
      step(1);
    end
    rst_n = 1'b1; enable = 1'b1; ovf_clr = 1'b0; irq.ready = 1'b0; req = 4'h0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_collision_overflow();
    test_enable_gating();
    test_reset_mid_offer();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_pending_arb.md
Name: irq_pending_arb

Overview:
- Sits directly upstream of the 4-input priority encoder stage.
- Synchronises 4 raw request lines, detects rising edges and latches them as pending bits.
- Selects the highest-priority pending request (bit 3 highest) and offers its 2-bit index to the downstream consumer over a valid/ready handshake.
- Clears the served pending bit on acceptance.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchroniser per request line; legal range 0..3 (0 = no synchroniser, req used directly).

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
enable  input  1  1 = capture new request edges; 0 = edges ignored (pending, offer and handshake unaffected)
req  input  4  raw request lines; req[3] highest priority
ovf_clr  input  1  synchronous clear of overflow
code  output  2  index (0..3) of request being offered
valid  output  1  code holds a request awaiting acceptance
ready  input  1  downstream accepts when valid && ready at a rising edge
pending  output  4  registered pending bits
overflow  output  1  sticky: an edge hit an already-pending bit

Behaviour:
- Reset (rst_n=0 at an edge): all synchroniser flops, edge-detect history, pending, code, valid, overflow -> 0; FSM -> IDLE. Reset overrides every other input.
- Reset mid-offer: offer is dropped with no handshake; request is lost.
- Synchroniser: s = req delayed by SYNC_STAGES flops (s = req when 0). s_q = s registered, reset 0.
- Edge: e[i] = s[i] & ~s_q[i].
- Power-up capture: a request line already high when reset releases produces one edge.
- Level-held lines produce exactly one edge. A line must return low for at least one synchronised cycle to re-trigger.
- Pending update per bit, each edge: set_i = e[i] & enable; clr_i = accept & (code==i); pending[i] <= set_i | (pending[i] & ~clr_i). Set wins over clear on the same bit in the same cycle (bit stays pending).
- Overflow: overflow <= 1 when set_i & pending[i] & ~clr_i for any i. ovf_clr=1 clears it. Set wins over ovf_clr in the same cycle. Sticky otherwise.
- FSM, 2 states:
  - IDLE: valid=0. If pending!=0 -> code <= index of highest set pending bit, valid <= 1, go OFFER. Else stay.
  - OFFER: valid=1, code frozen while !ready. No preemption: a higher-priority arrival does not change code. accept = valid & ready -> clear pending[code], valid <= 0, go IDLE.
  - Minimum one idle cycle between offers.
  - The selection in IDLE uses registered pending (excluding same-cycle sets).
- code holds its last value while valid=0 (0 after reset).
- enable=0 during OFFER: offer continues to completion; only new captures are blocked.
- Latency, req rising before edge k (k = first edge seeing req=1), SYNC_STAGES=S, FSM in IDLE, pending=0:
  - pending[i]=1 after edge k+S.
  - valid=1, code=i after edge k+S+1.
- Accept at edge m: valid=0 and pending bit cleared after m.
  - Next offer (if pending!=0) valid after edge m+1, re-arbitrated over the full pending set.
- Throughput: at most one accepted request per 2 cycles.

Test Plan:
- Reset then single request (S=2, enable=1, ready=0): req=0001 held from edge 1 -> pending=0001 after edge 3, valid=1 and code=0 after edge 4; hold ready=0 for 5 cycles -> code stays 0, valid stays 1; ready=1 at edge 10 -> valid=0, pending=0000 after edge 10.
- Priority ordering: req 0000->0101 in one cycle, ready=1 -> codes offered 2 then 0 on successive offers, each valid for exactly 1 cycle with 1 idle cycle between; pending 0101->0001->0000.
- No preemption: offer code=1 active with ready=0; raise req[3] -> pending becomes 1010, code remains 1; after accept, next offer code=3, then none pending for 3.
- Set/clear collision and overflow: while pending[2] is offered, drop and re-raise req[2] so its edge lands on the accept edge -> pending[2] stays 1, overflow stays 0, code=2 offered again. A second edge on req[0] while pending[0]=1 -> overflow=1. ovf_clr=1 one cycle -> overflow=0.
- Enable gating: enable=0, pulse req=1111 for 3 cycles -> pending stays 0000, valid stays 0. enable=1 with req held high -> no capture (no new edge). Drop to 0 and re-raise -> pending=1111.
- Reset mid-offer: valid=1, code=3, pending=1001, rst_n=0 for one edge -> all outputs 0. req held 1001 through reset -> after release, edges re-detected; pending=1001 after edge S+1 post-release, offer code=3.
